// File: rtl/systolic_array.sv
// systolic_array -- weight-stationary signed MAC tile.
//
// ROW_SIZE x COL_SIZE PEs hold W. Each streamed activation column x_j adds
// W * x_j into accumulator column C[:,j]. After a fixed drain interval the
// COL_SIZE result columns are emitted as ROW_SIZE-lane rows over valid/ready.
//
// The per-PE skew/propagation is collapsed into a per-row reduction at column
// accept time. The externally visible sequence is unchanged: ready, accept
// order, a fixed ROW_SIZE+COL_SIZE drain interval, and the output order.
//
// Optional build macro: SYSTOLIC_SATURATE_EN. When defined, every accumulator
// add saturates to the signed ACC_WIDTH range. When undefined, the add wraps
// (two's complement).
//
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   load_weights_i / execute_i      start pulses (load wins if both)
//   clear_accumulators_i            zero C (IDLE only)
//   weight_valid_i/_row_i/_ready_o  weight row stream, row r lane c at [c*DW +: DW]
//   activation_valid_i/_col_i/_ready_o  activation column stream
//   result_valid_o/_row_o/_ready_i  result rows C[:,j], lane i at [i*AW +: AW]
//   done_o                          1-cycle pulse after the final result pop

module systolic_row_mac #(
  parameter int COL_SIZE   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic [COL_SIZE-1:0][DATA_WIDTH-1:0] w_i,
  input  logic [COL_SIZE-1:0][DATA_WIDTH-1:0] x_i,
  input  logic [ACC_WIDTH-1:0]                acc_i,
  output logic [ACC_WIDTH-1:0]                acc_o
);
  logic signed [2*DATA_WIDTH-1:0] prod [COL_SIZE];
  logic signed [ACC_WIDTH-1:0]    sum;

  for (genvar k = 0; k < COL_SIZE; k++) begin : g_prod
    assign prod[k] = $signed(w_i[k]) * $signed(x_i[k]);
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < COL_SIZE; k++) sum = sum + ACC_WIDTH'(prod[k]);
  end

`ifdef SYSTOLIC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] MAXV = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MINV = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] wide;
  // One guard bit: overflow whenever the top two bits disagree.
  assign wide  = {acc_i[ACC_WIDTH-1], acc_i} + {sum[ACC_WIDTH-1], sum};
  assign acc_o = (wide[ACC_WIDTH] == wide[ACC_WIDTH-1]) ? wide[ACC_WIDTH-1:0]
               : (wide[ACC_WIDTH] ? MINV : MAXV);
`else
  assign acc_o = acc_i + sum;
`endif
endmodule

module systolic_array #(
  parameter int ROW_SIZE   = 8,
  parameter int COL_SIZE   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           weight_valid_i,
  input  logic [ROW_SIZE*DATA_WIDTH-1:0] weight_row_i,
  output logic                           weight_ready_o,
  input  logic                           activation_valid_i,
  input  logic [COL_SIZE*DATA_WIDTH-1:0] activation_col_i,
  output logic                           activation_ready_o,
  output logic                           result_valid_o,
  output logic [ROW_SIZE*ACC_WIDTH-1:0]  result_row_o,
  input  logic                           result_ready_i,
  input  logic                           load_weights_i,
  input  logic                           execute_i,
  input  logic                           clear_accumulators_i,
  output logic                           done_o
);
  localparam int RIW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int CIW = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int DCW = $clog2(ROW_SIZE + COL_SIZE);
  localparam logic [RIW-1:0] ROW_LAST   = RIW'(ROW_SIZE - 1);
  localparam logic [CIW-1:0] COL_LAST   = CIW'(COL_SIZE - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ROW_SIZE + COL_SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, OUTPUT} state_e;

  state_e                                             state_q;
  logic [ROW_SIZE-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0]  w_q;
  logic [COL_SIZE-1:0][ROW_SIZE-1:0][ACC_WIDTH-1:0]   acc_q;    // [j][i]
  logic [RIW-1:0]                                     row_q;
  logic [CIW-1:0]                                     col_q;    // compute column, then read column
  logic [DCW-1:0]                                     drn_q;
  logic weight_ready_q, act_ready_q, result_valid_q, done_q;

  logic [COL_SIZE-1:0][DATA_WIDTH-1:0] wrow;
  logic [COL_SIZE-1:0][DATA_WIDTH-1:0] xcol;
  logic [ROW_SIZE-1:0][ACC_WIDTH-1:0]  col_acc_d;

  assign xcol = activation_col_i;

  // Weight row lanes beyond COL_SIZE are ignored; missing lanes read as 0.
  for (genvar c = 0; c < COL_SIZE; c++) begin : g_wrow
    if (c < ROW_SIZE) begin : g_in
      assign wrow[c] = weight_row_i[c*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_zero
      assign wrow[c] = '0;
    end
  end

  for (genvar i = 0; i < ROW_SIZE; i++) begin : g_row
    systolic_row_mac #(
      .COL_SIZE  (COL_SIZE),
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
      .w_i  (w_q[i]),
      .x_i  (xcol),
      .acc_i(acc_q[col_q][i]),
      .acc_o(col_acc_d[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      w_q            <= '0;
      acc_q          <= '0;
      row_q          <= '0;
      col_q          <= '0;
      drn_q          <= '0;
      weight_ready_q <= 1'b0;
      act_ready_q    <= 1'b0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          row_q <= '0;
          col_q <= '0;
          drn_q <= '0;
          if (clear_accumulators_i) acc_q <= '0;
          if (load_weights_i) begin
            state_q        <= LOAD_W;
            weight_ready_q <= 1'b1;
          end else if (execute_i) begin
            state_q     <= COMPUTE;
            act_ready_q <= 1'b1;
          end
        end
        LOAD_W: if (weight_valid_i) begin
          w_q[row_q] <= wrow;
          if (row_q == ROW_LAST) begin
            state_q        <= IDLE;
            weight_ready_q <= 1'b0;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        COMPUTE: if (activation_valid_i) begin
          acc_q[col_q] <= col_acc_d;
          if (col_q == COL_LAST) begin
            state_q     <= DRAIN;
            act_ready_q <= 1'b0;
            col_q       <= '0;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drn_q == DRAIN_LAST) begin
            state_q        <= OUTPUT;
            result_valid_q <= 1'b1;
          end else begin
            drn_q <= drn_q + 1'b1;
          end
        end
        OUTPUT: if (result_ready_i) begin
          if (col_q == COL_LAST) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            done_q         <= 1'b1;
            col_q          <= '0;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign weight_ready_o     = weight_ready_q;
  assign activation_ready_o = act_ready_q;
  assign result_valid_o     = result_valid_q;
  assign done_o             = done_q;
  assign result_row_o       = result_valid_q ? acc_q[col_q] : '0;
endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: case table + scoreboard queue of
// expected result rows, plus hand sequences for reset and mid-run abort.
module tb_systolic_array;
  localparam int R = 8, C = 8, DW = 8, AW = 32;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic weight_valid_i = 1'b0, activation_valid_i = 1'b0, result_ready_i = 1'b0;
  logic load_weights_i = 1'b0, execute_i = 1'b0, clear_accumulators_i = 1'b0;
  logic [R*DW-1:0] weight_row_i = '0;
  logic [C*DW-1:0] activation_col_i = '0;
  logic weight_ready_o, activation_ready_o, result_valid_o, done_o;
  logic [R*AW-1:0] result_row_o;

  systolic_array #(.ROW_SIZE(R), .COL_SIZE(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .weight_valid_i(weight_valid_i), .weight_row_i(weight_row_i), .weight_ready_o(weight_ready_o),
    .activation_valid_i(activation_valid_i), .activation_col_i(activation_col_i),
    .activation_ready_o(activation_ready_o),
    .result_valid_o(result_valid_o), .result_row_o(result_row_o), .result_ready_i(result_ready_i),
    .load_weights_i(load_weights_i), .execute_i(execute_i),
    .clear_accumulators_i(clear_accumulators_i), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    clr;
    int    wsel;     // 0:i+k 1:sparse 2:-128 3:random
    int    xsel;     // 0:identity 1:e0,e1 2:zero 3:-128 4:ones 5:random
    bit    bp;       // toggle result_ready_i in OUTPUT
    int    chk_row;  // hand-computed spot value (row -1 = none)
    int    chk_lane;
    int    chk_val;
  } vec_t;

  int wm [R][C];     // W[i][k]
  int xm [C][C];     // x_j[k] as xm[j][k]
  int cm [R][C];     // C[i][j]
  logic [R*AW-1:0] sb [$];
  int npass = 0, ntot = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string nm, input logic [R*AW-1:0] act, input logic [R*AW-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic gen_w(input int sel);
    for (int i = 0; i < R; i++)
      for (int k = 0; k < C; k++)
        case (sel)
          0: wm[i][k] = i + k;
          1: wm[i][k] = (i == 0) ? ((k == 0) ? 1 : (k == 1) ? 2 : 0)
                      : (i == 1) ? ((k == 0) ? 3 : (k == 1) ? 4 : 0) : 0;
          2: wm[i][k] = -128;
          default: wm[i][k] = int'($urandom_range(0, 255)) - 128;
        endcase
  endtask

  task automatic gen_x(input int sel);
    for (int j = 0; j < C; j++)
      for (int k = 0; k < C; k++)
        case (sel)
          0: xm[j][k] = (j == k) ? 1 : 0;
          1: xm[j][k] = ((j == 0 && k == 0) || (j == 1 && k == 1)) ? 1 : 0;
          2: xm[j][k] = 0;
          3: xm[j][k] = -128;
          4: xm[j][k] = 1;
          default: xm[j][k] = int'($urandom_range(0, 255)) - 128;
        endcase
  endtask

  task automatic do_clear();
    clear_accumulators_i = 1'b1; tick(); clear_accumulators_i = 1'b0;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) cm[i][j] = 0;
  endtask

  task automatic do_load();
    load_weights_i = 1'b1; tick(); load_weights_i = 1'b0;
    check("wready_on", weight_ready_o, 1);
    for (int r = 0; r < R; r++) begin
      if (r == 3) begin weight_valid_i = 1'b0; tick(); end   // stall one cycle
      weight_valid_i = 1'b1;
      for (int c = 0; c < C; c++) weight_row_i[c*DW +: DW] = 8'(wm[r][c]);
      tick();
    end
    weight_valid_i = 1'b0;
    check("wready_off", weight_ready_o, 0);
  endtask

  task automatic start_exec();
    execute_i = 1'b1; tick(); execute_i = 1'b0;
    check("aready_on", activation_ready_o, 1);
  endtask

  task automatic drive_col(input int j);
    activation_valid_i = 1'b1;
    for (int k = 0; k < C; k++) activation_col_i[k*DW +: DW] = 8'(xm[j][k]);
    for (int i = 0; i < R; i++)
      for (int k = 0; k < C; k++) cm[i][j] += wm[i][k] * xm[j][k];
    tick();
    activation_valid_i = 1'b0;
  endtask

  task automatic run_exec(input bit bp, input int chk_row, input int chk_lane, input int chk_val);
    logic [R*AW-1:0] e;
    int n, rd, guard;
    bit rdy;
    start_exec();
    for (int j = 0; j < C; j++) begin
      if (j == 2) tick();                                    // valid-low stall
      drive_col(j);
    end
    for (int j = 0; j < C; j++) begin
      for (int i = 0; i < R; i++) e[i*AW +: AW] = cm[i][j];
      sb.push_back(e);
    end
    check("aready_off", activation_ready_o, 0);
    n = 0;
    while (!result_valid_o && n < 100) begin tick(); n++; end
    check("drain_latency", n, R + C);
    rd = 0; guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      rdy = bp ? (guard % 2 == 0) : 1'b1;
      result_ready_i = rdy;
      check($sformatf("rvalid%0d", rd), result_valid_o, 1);
      check($sformatf("row%0d", rd), result_row_o, sb[0]);
      if (rd == chk_row)
        check($sformatf("spot_r%0d_l%0d", chk_row, chk_lane),
              result_row_o[chk_lane*AW +: AW], chk_val);
      tick();
      if (rdy) begin void'(sb.pop_front()); rd++; end
      guard++;
    end
    result_ready_i = 1'b0;
    check("rows_popped", rd, C);
    check("done_pulse", done_o, 1);
    check("rvalid_off", result_valid_o, 0);
    tick();
    check("done_clear", done_o, 0);
    sb.delete();
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{"ident",  1, 0, 0, 0,  3, 2, 5};
    tbl[1] = '{"sparse", 1, 1, 1, 0,  0, 1, 3};
    tbl[2] = '{"accum",  0, 1, 1, 0,  0, 1, 6};
    tbl[3] = '{"zero",   1, 1, 2, 0,  1, 1, 0};
    tbl[4] = '{"neg",    1, 2, 3, 0,  5, 7, 131072};
    tbl[5] = '{"bp",     1, 0, 4, 1,  1, 2, 44};
    tbl[6] = '{"rand",   1, 3, 5, 1, -1, 0, 0};

    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) cm[i][j] = 0;

    // Reset state
    tick(); tick();
    check("rst_wready", weight_ready_o, 0);
    check("rst_aready", activation_ready_o, 0);
    check("rst_rvalid", result_valid_o, 0);
    check("rst_row", result_row_o, 0);
    check("rst_done", done_o, 0);
    rst_ni = 1'b1;
    tick();
    check("idle_wready", weight_ready_o, 0);

    for (int t = 0; t < 7; t++) begin
      if (tbl[t].clr) do_clear();
      gen_w(tbl[t].wsel);
      do_load();
      gen_x(tbl[t].xsel);
      run_exec(tbl[t].bp, tbl[t].chk_row, tbl[t].chk_lane, tbl[t].chk_val);
    end

    // Abort mid-compute with reset: W and C must both come back zero.
    gen_w(0); do_load();
    gen_x(4);
    start_exec();
    for (int j = 0; j < 3; j++) drive_col(j);
    rst_ni = 1'b0; #1;
    check("abort_aready", activation_ready_o, 0);
    check("abort_row", result_row_o, 0);
    tick(); rst_ni = 1'b1; tick();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < C; k++) begin wm[i][k] = 0; cm[i][k] = 0; end
    run_exec(0, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
